// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//
// Command-driven single-port RAM controller. Each valid command frame on din
// carries a 2-bit opcode in its top bits and a payload in its low bits:
//   00 : load write address     01 : write payload to mem[wr_addr]
//   10 : load read address      11 : read mem[rd_addr] into dout
// Read data is presented on a valid/ready handshake (tx_valid/tx_ready). A read
// issued while earlier data is still unconsumed and the consumer is not taking
// it on the same edge is dropped and flagged on rd_drop for one cycle.
//
// Configuration macro:
//   RAM_AUTOINC_EN : when defined, each executed write post-increments wr_addr
//                    and each accepted read post-increments rd_addr, wrapping
//                    from MEM_DEPTH-1 to 0.
//
// Parameters:
//   ADDR_W    address width in bits
//   DATA_W    memory word width in bits
//   MEM_DEPTH number of words (<= 2**ADDR_W); addresses are reduced modulo it
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   command frame, [MSB:MSB-1] opcode, low bits payload
//   rx_valid  in   din valid this cycle
//   tx_ready  in   consumer accepts dout this cycle
//   dout      out  registered read data
//   tx_valid  out  dout holds unconsumed read data
//   rd_drop   out  one-cycle pulse: a read command was discarded
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 2 ** ADDR_W
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic [((ADDR_W > DATA_W) ? ADDR_W : DATA_W)+1:0] din,
  input  logic                                            rx_valid,
  input  logic                                            tx_ready,
  output logic [DATA_W-1:0]                               dout,
  output logic                                            tx_valid,
  output logic                                            rd_drop
);

  localparam int FRAME_W = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 2;
  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // Depth held one bit wider than an address so 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Reduce a stored address into the physical word range.
  function automatic logic [IDX_W-1:0] to_index(input logic [ADDR_W-1:0] a);
    to_index = IDX_W'({1'b0, a} % DEPTH_L);
  endfunction

`ifdef RAM_AUTOINC_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

  // Post-increment of a reduced index, wrapping at the top of memory.
  function automatic logic [ADDR_W-1:0] next_index(input logic [IDX_W-1:0] i);
    if (i == LAST_IDX) begin
      next_index = {ADDR_W{1'b0}};
    end else begin
      next_index = ADDR_W'(i) + ADDR_W'(1);
    end
  endfunction
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  state_t            state_q,   state_d;
  logic [DATA_W-1:0] dout_q,    dout_d;
  logic              rd_drop_q, rd_drop_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [1:0]        opcode_s;
  logic              wr_cmd_s;
  logic              rd_cmd_s;
  logic              rd_accept_s;
  logic              rd_discard_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;

  assign opcode_s = din[FRAME_W-1 -: 2];
  assign wr_idx_s = to_index(wr_addr_q);
  assign rd_idx_s = to_index(rd_addr_q);

  // Command decode and read acceptance: a read is taken unless old data is
  // still pending and the consumer is not draining it on this edge.
  always_comb begin
    wr_cmd_s     = rx_valid && (opcode_s == OP_WRITE);
    rd_cmd_s     = rx_valid && (opcode_s == OP_READ);
    rd_accept_s  = rd_cmd_s && ((state_q == IDLE) || tx_ready);
    rd_discard_s = rd_cmd_s && (state_q == HOLD) && !tx_ready;
  end

  // Next-state logic for the handshake FSM, read data and address registers.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    rd_drop_d = rd_discard_s;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (rd_accept_s) begin
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (rd_accept_s) begin
          state_d = HOLD;
        end else if (tx_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_accept_s) begin
      dout_d = mem[rd_idx_s];
    end else begin
      dout_d = dout_q;
    end

    if (rx_valid) begin
      case (opcode_s)
        OP_WADDR: wr_addr_d = din[ADDR_W-1:0];
        OP_RADDR: rd_addr_d = din[ADDR_W-1:0];
`ifdef RAM_AUTOINC_EN
        OP_WRITE: wr_addr_d = next_index(wr_idx_s);
        OP_READ: begin
          if (rd_accept_s) begin
            rd_addr_d = next_index(rd_idx_s);
          end else begin
            rd_addr_d = rd_addr_q;
          end
        end
`endif
        default: begin
          wr_addr_d = wr_addr_q;
          rd_addr_d = rd_addr_q;
        end
      endcase
    end else begin
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
    end
  end

  // Control and output registers; reset drops any pending read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dout_q    <= {DATA_W{1'b0}};
      rd_drop_q <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      rd_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      rd_drop_q <= rd_drop_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Storage array; deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_cmd_s) begin
      mem[wr_idx_s] <= din[DATA_W-1:0];
    end
  end

  assign dout     = dout_q;
  assign tx_valid = (state_q == HOLD);
  assign rd_drop  = rd_drop_q;

endmodule
